// File: rtl/mano_io_pkg.sv
// Shared types for the serial printer: accept/transmit FSM states and frame geometry.
package mano_io_pkg;

  typedef enum logic {
    ACC_IDLE,
    ACC_WAIT
  } acc_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/char_fifo.sv
// Character buffer between the CPU accept path and the serial shifter.
module char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_INC  = AW'(1);
  localparam logic [AW:0]   CNT_INC  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop frees the slot in the same cycle, so a full FIFO still takes a push alongside it.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_INC;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_INC;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_INC;
        2'b01:   r_count <= r_count - CNT_INC;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/serial_printer.sv
// Takes characters from the CPU output register handshake and shifts them out as 8N1 frames.
module serial_printer
  import mano_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       fgo_in,
  output logic       fgo_set_out,
  output logic       tx_out,
  output logic       busy_out
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  acc_state_t  r_acc_state;
  tx_state_t   r_tx_state;
  logic [15:0] r_bit_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_bit_end;
  logic        w_line;
  logic [7:0]  w_head;

  char_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (data_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop       = (r_tx_state == TX_IDLE) && !w_empty;
  assign w_push      = (r_acc_state == ACC_IDLE) && !fgo_in && (!w_full || w_pop);
  assign w_bit_end   = (r_bit_cnt == BIT_LAST);
  assign fgo_set_out = w_push;
  assign tx_out      = r_tx;
  assign busy_out    = !w_empty || (r_tx_state != TX_IDLE);

  // ACC_WAIT blocks a second push of the same character until the CPU has seen the flag set.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_acc_state <= ACC_IDLE;
    end else begin
      case (r_acc_state)
        ACC_IDLE: if (w_push) r_acc_state <= ACC_WAIT;
        ACC_WAIT: if (fgo_in) r_acc_state <= ACC_IDLE;
      endcase
    end
  end

  always_comb begin
    w_line = 1'b1;
    case (r_tx_state)
      TX_START: w_line = 1'b0;
      TX_DATA:  w_line = r_shift[0];
      default:  w_line = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_pop) r_shift <= w_head;
    else if ((r_tx_state == TX_DATA) && w_bit_end) r_shift <= {1'b0, r_shift[7:1]};
  end

  // The line register trails the state by one cycle, so the start bit shows one edge after the pop.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_tx_state <= TX_IDLE;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx <= w_line;
      case (r_tx_state)
        TX_IDLE: begin
          r_bit_cnt <= '0;
          r_bit_idx <= '0;
          if (w_pop) r_tx_state <= TX_START;
        end
        TX_START: begin
          if (w_bit_end) begin
            r_bit_cnt  <= '0;
            r_tx_state <= TX_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_tx_state <= TX_STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            r_bit_cnt  <= '0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule
